ps_rr_arbiter: RTL and testbench

Round-robin packet arbiter that merges CHANNELS PacketStream sources into a single PacketStream sink, such as a shared single-clock packet FIFO. Packets are never interleaved: once a channel is granted, it owns the output until its eop beat is accepted. The output is driven from a 2-entry skid register, so every output is registered and the accepted path sustains full throughput.

---
 rtl/ps_rr_arbiter_pkg.sv | 40 ++++
 rtl/ps_rr_arbiter_if.sv | 41 ++++
 rtl/ps_rr_arbiter_skid.sv | 53 +++++
 rtl/ps_rr_arbiter.sv | 102 ++++++++++
 tb/tb_ps_rr_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps_rr_arbiter_pkg.sv
// ps_arb_pkg: shared types and helpers for the round-robin packet arbiter.
// Optional feature macro used across the slice: PS_RR_ARBITER_CHN_EN
// (carries the source channel index with every output beat on o_chn).
package ps_arb_pkg;

  // Upper bound on channel count understood by rr_pick.
  localparam int MAX_CH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int cwidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin pick: first set bit of req scanning ptr+1, ptr+2, ...
  // modulo n. Returns ptr when nothing is requesting.
  function automatic int rr_pick(input logic [MAX_CH-1:0] req,
                                 input int ptr, input int n);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= MAX_CH; k++) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[4:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/ps_rr_arbiter_if.sv
// ps_rr_arbiter_if: CHANNELS PacketStream sources in, one PacketStream out.
// o_chn exists only when PS_RR_ARBITER_CHN_EN is defined.
//
// Handshake: a beat moves on a port in any cycle where val and rdy are both
// high at the rising clock edge. While val is high and rdy is low the sender
// holds dat/eop(/chn) unchanged. rdy may be asserted without val.
interface ps_rr_arbiter_if
  import ps_arb_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int CHANNELS = 4
);
  localparam int CWIDTH = cwidth(CHANNELS);

  logic [CHANNELS-1:0][DWIDTH-1:0] i_dat;
  logic [CHANNELS-1:0]             i_val;
  logic [CHANNELS-1:0]             i_eop;
  logic [CHANNELS-1:0]             i_rdy;
  logic [DWIDTH-1:0]               o_dat;
  logic                            o_val;
  logic                            o_eop;
  logic                            o_rdy;
`ifdef PS_RR_ARBITER_CHN_EN
  logic [CWIDTH-1:0]               o_chn;

  // Arbiter side.
  modport slave (input i_dat, i_val, i_eop, o_rdy,
                 output i_rdy, o_dat, o_val, o_eop, o_chn);
  // Sources and sink side.
  modport master (output i_dat, i_val, i_eop, o_rdy,
                  input i_rdy, o_dat, o_val, o_eop, o_chn);
`else
  // Arbiter side.
  modport slave (input i_dat, i_val, i_eop, o_rdy,
                 output i_rdy, o_dat, o_val, o_eop);
  // Sources and sink side.
  modport master (output i_dat, i_val, i_eop, o_rdy,
                  input i_rdy, o_dat, o_val, o_eop);
`endif

endinterface

// File: rtl/ps_rr_arbiter_skid.sv
// ps_arb_skid: 2-entry registered skid buffer. Stage A drives the output;
// stage B catches a beat accepted while A is stalled. skid_full (B occupied)
// is registered and is what the arbiter uses to drop its input ready.
module ps_arb_skid #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_dat,
  input  logic         in_val,
  output logic [W-1:0] out_dat,
  output logic         out_val,
  input  logic         out_rdy,
  output logic         skid_full
);

  logic [W-1:0] a_dat, b_dat;
  logic         a_val, b_val;
  logic         a_cons;

  assign a_cons = a_val & out_rdy;

  // Stage update. in_val is never high while B is full because the
  // arbiter gates its ready with skid_full, so B only ever drains into A.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_dat <= '0;
      a_val <= 1'b0;
      b_dat <= '0;
      b_val <= 1'b0;
    end else if (b_val) begin
      if (a_cons) begin
        a_dat <= b_dat;
        b_val <= 1'b0;
      end
    end else if (in_val) begin
      if (!a_val || a_cons) begin
        a_dat <= in_dat;
        a_val <= 1'b1;
      end else begin
        b_dat <= in_dat;
        b_val <= 1'b1;
      end
    end else if (a_cons) begin
      a_val <= 1'b0;
    end
  end

  assign out_dat   = a_dat;
  assign out_val   = a_val;
  assign skid_full = b_val;

endmodule

// File: rtl/ps_rr_arbiter.sv
// ps_rr_arbiter: round-robin packet arbiter, CHANNELS sources onto one sink.
// A granted channel owns the output until its eop beat is accepted; the
// output is fully registered through ps_arb_skid.
// Optional: define PS_RR_ARBITER_CHN_EN to add o_chn (source index per beat).
module ps_rr_arbiter
  import ps_arb_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ps_rr_arbiter_if.slave        bus,
  output state_t                dbg_state
);

  localparam int CWIDTH = cwidth(CHANNELS);
`ifdef PS_RR_ARBITER_CHN_EN
  localparam int SW = DWIDTH + 1 + CWIDTH;
`else
  localparam int SW = DWIDTH + 1;
`endif

  state_t              state, state_n;
  logic [CWIDTH-1:0]   gnt, gnt_n;
  logic [CWIDTH-1:0]   ptr, ptr_n;
  logic [CHANNELS-1:0] i_rdy_c;
  logic                acc;
  logic                skid_full;
  logic [MAX_CH-1:0]   req;
  logic [SW-1:0]       in_beat;
  logic [SW-1:0]       out_beat;

  assign req = MAX_CH'(bus.i_val);

  // State, grant and round-robin pointer registers. ptr starts at the last
  // channel so channel 0 wins the first arbitration after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= CWIDTH'(CHANNELS - 1);
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
    end
  end

  // Next state, grant selection and per-channel ready.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = ptr;
    i_rdy_c = '0;
    acc     = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.i_val) begin
          gnt_n   = CWIDTH'(rr_pick(req, int'(ptr), CHANNELS));
          state_n = LOCK;
        end
      end
      LOCK: begin
        // Lock is held across source gaps; only an accepted eop releases it.
        i_rdy_c[gnt] = ~skid_full;
        acc          = bus.i_val[gnt] & ~skid_full;
        if (acc && bus.i_eop[gnt]) begin
          ptr_n   = gnt;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef PS_RR_ARBITER_CHN_EN
  assign in_beat = {gnt, bus.i_eop[gnt], bus.i_dat[gnt]};
`else
  assign in_beat = {bus.i_eop[gnt], bus.i_dat[gnt]};
`endif

  ps_arb_skid #(.W(SW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_dat    (in_beat),
    .in_val    (acc),
    .out_dat   (out_beat),
    .out_val   (bus.o_val),
    .out_rdy   (bus.o_rdy),
    .skid_full (skid_full)
  );

  assign bus.i_rdy = i_rdy_c;
  assign bus.o_dat = out_beat[DWIDTH-1:0];
  assign bus.o_eop = out_beat[DWIDTH];
`ifdef PS_RR_ARBITER_CHN_EN
  assign bus.o_chn = out_beat[SW-1 -: CWIDTH];
`endif
  assign dbg_state = state;

endmodule

// File: tb/tb_ps_rr_arbiter.sv
// Bench for ps_rr_arbiter: packet batches are staged per channel, the
// expected merged stream is derived packet-by-packet from round-robin order,
// and a monitor pops and compares every output beat.
module tb_ps_rr_arbiter;
  import ps_arb_pkg::*;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int CW = cwidth(CH);
  localparam int BW = DW + 1;
  localparam int EW = CW + BW;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  int     cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ps_rr_arbiter_if #(.DWIDTH(DW), .CHANNELS(CH)) bus();

  ps_rr_arbiter #(.DWIDTH(DW), .CHANNELS(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- bench state ----------------
  int              compared   = 0;
  int              mismatched = 0;
  logic [EW-1:0]   exp_q[$];
  logic [BW-1:0]   src_q[CH][$];
  logic [BW-1:0]   stg_q[CH][$];
  int              stg_len[CH][$];
  int              stamp_q[$];
  logic            ordy_q[$];
  logic [CH-1:0]   acc_s = '0;
  logic [CH-1:0]   mid   = '0;
  int              drop_cnt[CH];
  bit              ordy_rand = 0;
  bit              drop_rand = 0;
  int              inflight  = 0;
  int              max_inflight = 0;
  int              ptr_m     = CH - 1;
  int              seq       = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver: sources and sink ready ----------------
  initial begin
    bus.i_val = '0;
    bus.i_dat = '0;
    bus.i_eop = '0;
    bus.o_rdy = 1'b1;
    for (int c = 0; c < CH; c++) drop_cnt[c] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (acc_s[c] && src_q[c].size() > 0) begin
          mid[c] = ~src_q[c][0][DW];
          void'(src_q[c].pop_front());
        end
      end
      acc_s = '0;
      for (int c = 0; c < CH; c++) begin
        logic v;
        v = 1'b0;
        if (src_q[c].size() > 0) begin
          v = 1'b1;
          if (mid[c] && drop_cnt[c] > 0) begin
            v = 1'b0;
            drop_cnt[c]--;
          end else if (mid[c] && drop_rand && $urandom_range(0, 3) == 0) begin
            v = 1'b0;
          end
          bus.i_dat[c] = src_q[c][0][DW-1:0];
          bus.i_eop[c] = src_q[c][0][DW];
        end
        bus.i_val[c] = v;
      end
      if (ordy_q.size() > 0) bus.o_rdy = ordy_q.pop_front();
      else if (ordy_rand)    bus.o_rdy = ($urandom_range(0, 3) != 0);
      else                   bus.o_rdy = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("i_rdy_onehot0", ($countones(bus.i_rdy) <= 1), 1);
        check("o_val_vs_held_beats", bus.o_val, (inflight > 0));
        if (inflight >= 2) check("i_rdy_low_when_skid_full", bus.i_rdy, 0);
        acc_s = bus.i_val & bus.i_rdy;
        if (bus.o_val && bus.o_rdy) begin
          stamp_q.push_back(cyc);
          inflight--;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_beat: got %0h, expected no beat (cycle %0d)",
                     {bus.o_eop, bus.o_dat}, cyc);
          end else begin
            e = exp_q.pop_front();
            check("beat_dat", bus.o_dat, e[DW-1:0]);
            check("beat_eop", bus.o_eop, e[DW]);
`ifdef PS_RR_ARBITER_CHN_EN
            check("beat_chn", bus.o_chn, e[EW-1 -: CW]);
`endif
          end
        end
        inflight += $countones(acc_s);
        if (inflight > max_inflight) max_inflight = inflight;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic stage_pkt(input int c, input int len);
    logic [1:0] ch;
    ch = 2'(c);
    for (int i = 0; i < len; i++) begin
      stg_q[c].push_back({(i == len - 1), ch, 6'(seq)});
      seq++;
    end
    stg_len[c].push_back(len);
  endtask

  task automatic stage_fixed(input int c, input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++)
      stg_q[c].push_back({(i == len - 1), base + DW'(i)});
    stg_len[c].push_back(len);
  endtask

  // Expected stream: whole packets in round-robin order among channels that
  // still have packets; then hand the staged beats to the sources.
  task automatic launch();
    int rem[CH];
    int pos[CH];
    int pk[CH];
    int cur, pick, len;
    bit any;
    for (int c = 0; c < CH; c++) begin
      rem[c] = stg_len[c].size();
      pos[c] = 0;
      pk[c]  = 0;
    end
    cur = ptr_m;
    any = 1;
    while (any) begin
      any  = 0;
      pick = 0;
      for (int k = 1; k <= CH; k++)
        if (!any && rem[(cur + k) % CH] > 0) begin
          any  = 1;
          pick = (cur + k) % CH;
        end
      if (any) begin
        len = stg_len[pick][pk[pick]];
        for (int i = 0; i < len; i++)
          exp_q.push_back({CW'(pick), stg_q[pick][pos[pick] + i]});
        pos[pick] += len;
        pk[pick]++;
        rem[pick]--;
        cur = pick;
      end
    end
    ptr_m = cur;
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      foreach (stg_q[c][i]) src_q[c].push_back(stg_q[c][i]);
      stg_q[c].delete();
      stg_len[c].delete();
    end
  endtask

  function automatic bit src_busy();
    bit b;
    b = 0;
    for (int c = 0; c < CH; c++) if (src_q[c].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || src_busy()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    if (exp_q.size() > 0 || src_busy()) begin
      exp_q.delete();
      for (int c = 0; c < CH; c++) src_q[c].delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_mid(input int c);
    int n;
    n = 0;
    while (!mid[c] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_mid_packet", mid[c], 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rise;
    int n;
    logic [CH-1:0] others;

    #2 reset = 1'b0;
    #1;
    check("reset_o_val", bus.o_val, 0);
    check("reset_o_eop", bus.o_eop, 0);
    check("reset_o_dat", bus.o_dat, 0);
    check("reset_i_rdy", bus.i_rdy, 0);
    check("reset_state", dbg_state, IDLE);
`ifdef PS_RR_ARBITER_CHN_EN
    check("reset_o_chn", bus.o_chn, 0);
`endif
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // All channels, 1-beat packets: 0,1,2,3,0,... one bubble per packet.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++) stage_pkt(c, 1);
    stamp_q.delete();
    launch();
    drain("rr_one_beat");
    check("rr_beat_count", stamp_q.size(), 8);
    for (int i = 1; i < stamp_q.size(); i++)
      check("rr_bubble_gap", stamp_q[i] - stamp_q[i-1], 2);

    // Single packet on ch2: A1, A2, A3(eop); first o_val two cycles in.
    stage_fixed(2, 3, 8'hA1);
    stamp_q.delete();
    launch();
    @(posedge clk);
    #2;
    rise = cyc;
    check("single_i_val_rise", bus.i_val[2], 1);
    drain("single_pkt");
    check("single_beat_count", stamp_q.size(), 3);
    if (stamp_q.size() == 3) begin
      check("single_first_latency", stamp_q[0] - rise, 2);
      check("single_gap1", stamp_q[1] - stamp_q[0], 1);
      check("single_gap2", stamp_q[2] - stamp_q[1], 1);
    end

    // ch1 4-beat packet competing with ch0 and ch3, pointer left at 0.
    stage_pkt(0, 1);
    launch();
    drain("set_ptr0");
    stage_pkt(1, 4);
    stage_pkt(0, 1);
    stage_pkt(3, 1);
    launch();
    drain("no_interleave");

    // 8-beat packet while o_rdy goes 1,0,0,1.
    stage_pkt(2, 8);
    stamp_q.delete();
    max_inflight = 0;
    launch();
    n = 0;
    while (stamp_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_start", (stamp_q.size() >= 2), 1);
    ordy_q.push_back(1'b1);
    ordy_q.push_back(1'b0);
    ordy_q.push_back(1'b0);
    ordy_q.push_back(1'b1);
    drain("ordy_stall");
    check("stall_beat_count", stamp_q.size(), 8);
    check("stall_skid_depth", max_inflight, 2);

    // ch0 drops i_val for 5 cycles mid-packet; lock must hold.
    stage_pkt(0, 8);
    stage_pkt(1, 2);
    stage_pkt(3, 1);
    launch();
    wait_mid(0);
    drop_cnt[0] = 5;
    others = ~CH'(1);
    repeat (5) begin
      @(negedge clk);
      check("drop_lock_hold", bus.i_rdy & others, 0);
    end
    drain("drop_resume");

    // Reset in the middle of a packet, then channel 0 wins first.
    stage_pkt(1, 6);
    stage_pkt(2, 2);
    launch();
    wait_mid(1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_o_val", bus.o_val, 0);
    check("midreset_i_rdy", bus.i_rdy, 0);
    check("midreset_state", dbg_state, IDLE);
    exp_q.delete();
    for (int c = 0; c < CH; c++) begin
      src_q[c].delete();
      drop_cnt[c] = 0;
    end
    mid      = '0;
    acc_s    = '0;
    inflight = 0;
    ptr_m    = CH - 1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    stage_pkt(3, 2);
    stage_pkt(2, 2);
    stage_pkt(0, 2);
    launch();
    drain("after_reset");

    // Randomized batches with sink stalls and source gaps.
    ordy_rand = 1;
    drop_rand = 1;
    repeat (25) begin
      for (int c = 0; c < CH; c++) begin
        n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++) stage_pkt(c, $urandom_range(1, 6));
      end
      launch();
      drain("random_batch");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Overall time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d",
             compared, mismatched);
    $fatal(1);
  end

endmodule
